// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI slave receive path.
package spi_pkg;

    localparam int   SPI_WIDTH = 8;
    localparam logic SCLK_IDLE = 1'b0;
    localparam logic SS_IDLE   = 1'b1;

    typedef logic [SPI_WIDTH-1:0] spi_byte_t;

endpackage

// File: rtl/spi_sync.sv
// N-stage flop chain that brings an asynchronous pin into the clock domain,
// loading a caller-chosen idle level on reset.
module spi_sync #(
    parameter int STAGES = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic rst_val,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] stage;

    always_ff @(posedge clock) begin
        if (reset) begin
            stage <= {STAGES{rst_val}};
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/spi_slave_rx.sv
// Receive-only SPI mode-0 slave: synchronizes the pins and shifts MOSI, MSB first.
// Optional byte-complete pulse (io_byteValid) when SPI_SLAVE_BYTE_VALID_EN is defined.
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 1,
    parameter int WIDTH       = SPI_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_SPISignals_SCLK,
    input  logic             io_SPISignals_MOSI,
    input  logic             io_SPISignals_SS,
    output logic [WIDTH-1:0] io_currentByte,
    output logic             io_isCurrentlyReading
`ifdef SPI_SLAVE_BYTE_VALID_EN
    ,
    output logic             io_byteValid
`endif
);

    logic             sclk_s;
    logic             mosi_s;
    logic             ss_s;
    logic             sclk_prev;
    logic             rise;
    logic             accept;
    logic [WIDTH-1:0] shreg;

    // Equal depth on all three pins keeps MOSI/SS aligned with the SCLK edge.
    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clock   (clock),
        .reset   (reset),
        .rst_val (SCLK_IDLE),
        .d       (io_SPISignals_SCLK),
        .q       (sclk_s)
    );

    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clock   (clock),
        .reset   (reset),
        .rst_val (1'b0),
        .d       (io_SPISignals_MOSI),
        .q       (mosi_s)
    );

    spi_sync #(.STAGES(SYNC_STAGES)) u_sync_ss (
        .clock   (clock),
        .reset   (reset),
        .rst_val (SS_IDLE),
        .d       (io_SPISignals_SS),
        .q       (ss_s)
    );

    assign rise   = sclk_s & ~sclk_prev;
    assign accept = rise & ~ss_s;

    // No bit counter: the register always holds the most recent WIDTH bits.
    always_ff @(posedge clock) begin
        if (reset) begin
            sclk_prev <= SCLK_IDLE;
            shreg     <= '0;
        end else begin
            sclk_prev <= sclk_s;
            if (accept) begin
                shreg <= {shreg[WIDTH-2:0], mosi_s};
            end
        end
    end

    assign io_currentByte        = shreg;
    assign io_isCurrentlyReading = ~ss_s;

`ifdef SPI_SLAVE_BYTE_VALID_EN
    logic [2:0] bit_cnt;
    logic       byte_valid_q;

    // Pulse lands in the same cycle the 8th bit becomes visible in shreg.
    always_ff @(posedge clock) begin
        if (reset) begin
            bit_cnt      <= 3'd0;
            byte_valid_q <= 1'b0;
        end else begin
            byte_valid_q <= accept && (bit_cnt == 3'd7);
            if (ss_s) begin
                bit_cnt <= 3'd0;
            end else if (accept) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    assign io_byteValid = byte_valid_q;
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: pin-level SPI stimulus against a bit-history model.
// Define SPI_SLAVE_BYTE_VALID_EN to also score io_byteValid pulses.
module tb_spi_slave_rx;
    import spi_pkg::*;

    localparam int SYNC_STAGES = 1;
    localparam int W           = SPI_WIDTH;
    localparam int CLK_HALF    = 1000;
    localparam int SCLK_HALF   = 5000;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         sclk  = 1'b0;
    logic         mosi  = 1'b0;
    logic         ss    = 1'b1;
    logic [W-1:0] current_byte;
    logic         reading;
`ifdef SPI_SLAVE_BYTE_VALID_EN
    logic         byte_valid;
    int           pulse_cnt = 0;
`endif

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] exp_q[$];
    bit           bits_q[$];
    int           model_cnt = 0;

    // ---------------- clock / reset ----------------
    always #CLK_HALF clock = ~clock;

    spi_slave_rx #(.SYNC_STAGES(SYNC_STAGES), .WIDTH(W)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .io_SPISignals_SCLK    (sclk),
        .io_SPISignals_MOSI    (mosi),
        .io_SPISignals_SS      (ss),
        .io_currentByte        (current_byte),
        .io_isCurrentlyReading (reading)
`ifdef SPI_SLAVE_BYTE_VALID_EN
        ,
        .io_byteValid          (byte_valid)
`endif
    );

    // ---------------- reference model ----------------
    // Expected byte: bit k is the k-th most recent accepted bit (0 if fewer).
    function automatic logic [W-1:0] model_byte();
        logic [W-1:0] v;
        int n;
        v = '0;
        n = bits_q.size();
        for (int k = 0; k < W; k++) begin
            if (k < n) v[k] = bits_q[n-1-k];
        end
        return v;
    endfunction

    task automatic model_accept(input bit b);
        bits_q.push_back(b);
        model_cnt++;
        if (model_cnt % 8 == 0) exp_q.push_back(model_byte());
    endtask

    task automatic model_reset();
        bits_q.delete();
        exp_q.delete();
        model_cnt = 0;
    endtask

    // ---------------- driver tasks ----------------
    // Move input changes half a clock-phase away from any clock edge.
    task automatic align();
        @(negedge clock);
        #(CLK_HALF / 2);
    endtask

    task automatic settle();
        repeat (SYNC_STAGES + 3) @(negedge clock);
    endtask

    task automatic send_bit(input bit b);
        mosi = b;
        #SCLK_HALF;
        sclk = 1'b1;
        if (ss == 1'b0) model_accept(b);
        #SCLK_HALF;
        sclk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic ss_low();
        ss = 1'b0;
        #SCLK_HALF;
    endtask

    task automatic ss_high();
        ss = 1'b1;
        model_cnt = 0;
        #SCLK_HALF;
    endtask

    // ---------------- scoreboard for byte-valid pulses ----------------
`ifdef SPI_SLAVE_BYTE_VALID_EN
    always @(negedge clock) begin
        if (byte_valid === 1'b1) begin
            logic [W-1:0] e;
            pulse_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL byte_valid_unexpected: pulse with byte %h, none expected", current_byte);
            end else begin
                e = exp_q.pop_front();
                if (current_byte !== e) begin
                    errors++;
                    $display("FAIL byte_valid_data: got %h want %h", current_byte, e);
                end
            end
        end
    end
`endif

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int n;
        reset = 1'b1;
        ss    = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (current_byte !== '0) begin
            errors++;
            $display("FAIL reset_byte: got %h want 00", current_byte);
        end
        checks++;
        if (reading !== 1'b0) begin
            errors++;
            $display("FAIL reset_reading: got %b want 0", reading);
        end
        reset = 1'b0;
        model_reset();
        n = 0;
        while (reading !== 1'b1 && n < 10) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n !== SYNC_STAGES) begin
            errors++;
            $display("FAIL reset_release_latency: got %0d clocks want %0d", n, SYNC_STAGES);
        end
        align();
        ss_high();
        settle();
    endtask

    task automatic test_ss_high_ignored();
        align();
        for (int i = 0; i < 16; i++) send_bit(1'b1);
        settle();
        checks++;
        if (current_byte !== model_byte()) begin
            errors++;
            $display("FAIL ss_high_byte: got %h want %h", current_byte, model_byte());
        end
        checks++;
        if (reading !== 1'b0) begin
            errors++;
            $display("FAIL ss_high_reading: got %b want 0", reading);
        end
    endtask

    task automatic test_nine_bits();
        logic [8:0] pattern;
        pattern = 9'b000100000;
        align();
        ss_low();
        for (int i = 8; i >= 0; i--) send_bit(pattern[i]);
        settle();
        checks++;
        if (current_byte !== model_byte()) begin
            errors++;
            $display("FAIL nine_bits_byte: got %h want %h", current_byte, model_byte());
        end
        checks++;
        if (reading !== 1'b1) begin
            errors++;
            $display("FAIL nine_bits_reading: got %b want 1", reading);
        end
        align();
        ss_high();
        settle();
    endtask

    task automatic test_a5_hold();
        align();
        ss_low();
        send_byte(8'hA5);
        settle();
        checks++;
        if (current_byte !== model_byte()) begin
            errors++;
            $display("FAIL a5_byte: got %h want %h", current_byte, model_byte());
        end
        align();
        ss_high();
        settle();
        checks++;
        if (current_byte !== model_byte()) begin
            errors++;
            $display("FAIL a5_hold_after_ss: got %h want %h", current_byte, model_byte());
        end
        checks++;
        if (reading !== 1'b0) begin
            errors++;
            $display("FAIL a5_reading_after_ss: got %b want 0", reading);
        end
        align();
        ss_low();
        settle();
        checks++;
        if (current_byte !== model_byte()) begin
            errors++;
            $display("FAIL a5_hold_on_reselect: got %h want %h", current_byte, model_byte());
        end
        checks++;
        if (reading !== 1'b1) begin
            errors++;
            $display("FAIL reselect_reading: got %b want 1", reading);
        end
        align();
        ss_high();
    endtask

    task automatic test_reset_mid();
        align();
        ss_low();
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        checks++;
        if (current_byte !== model_byte()) begin
            errors++;
            $display("FAIL reset_mid_byte: got %h want %h", current_byte, model_byte());
        end
        checks++;
        if (reading !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_reading: got %b want 0", reading);
        end
        align();
        #SCLK_HALF;
        send_byte(8'h3C);
        settle();
        checks++;
        if (current_byte !== model_byte()) begin
            errors++;
            $display("FAIL reset_mid_resume: got %h want %h", current_byte, model_byte());
        end
        align();
        ss_high();
        settle();
    endtask

    task automatic test_random();
        int nbits;
        int nidle;
        for (int t = 0; t < 6; t++) begin
            align();
            nidle = $urandom_range(0, 3);
            for (int i = 0; i < nidle; i++) send_bit(1'($urandom_range(0, 1)));
            ss_low();
            nbits = $urandom_range(1, 20);
            for (int i = 0; i < nbits; i++) send_bit(1'($urandom_range(0, 1)));
            settle();
            checks++;
            if (current_byte !== model_byte()) begin
                errors++;
                $display("FAIL random_xfer%0d: got %h want %h", t, current_byte, model_byte());
            end
            align();
            ss_high();
        end
        settle();
    endtask

    // SCLK rise and SS release seen in the same synchronized sample: bit is dropped.
    task automatic test_simultaneous();
        align();
        ss_low();
        send_byte(8'($urandom_range(0, 255)));
        mosi = ~current_byte[0];
        #SCLK_HALF;
        sclk = 1'b1;
        ss   = 1'b1;
        model_cnt = 0;
        #SCLK_HALF;
        sclk = 1'b0;
        settle();
        checks++;
        if (current_byte !== model_byte()) begin
            errors++;
            $display("FAIL simultaneous_rise_ss: got %h want %h", current_byte, model_byte());
        end
    endtask

`ifdef SPI_SLAVE_BYTE_VALID_EN
    task automatic test_byte_valid();
        int start;
        start = pulse_cnt;
        align();
        ss_low();
        send_byte(8'h12);
        send_byte(8'h34);
        settle();
        checks++;
        if (pulse_cnt - start !== 2) begin
            errors++;
            $display("FAIL byte_valid_count: got %0d pulses want 2", pulse_cnt - start);
        end
        align();
        ss_high();
        settle();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL byte_valid_missing: got %0d unmatched want 0", exp_q.size());
        end
    endtask
`endif

    initial begin
        #(50_000_000);
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_ss_high_ignored();
        test_nine_bits();
        test_a5_hold();
        test_reset_mid();
        test_random();
        test_simultaneous();
`ifdef SPI_SLAVE_BYTE_VALID_EN
        test_byte_valid();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
